ifetch_sequencer: RTL and testbench
===================================

IFETCH_SEQUENCER -- requirements
Module: ifetch_sequencer

Interface
REQ-001 Parameter WORD_WIDTH, default 32, SHALL set the instruction and data width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC loaded on reset.
REQ-003 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have exactly these ports:
  clk  in  1  sole clock, all state updates on rising edge
  reset  in  1  synchronous, active-high reset
  redirect_e  in  1  taken branch/jump from execute
  pc_target_e  in  32  redirect target
  stall_d  in  1  decode cannot accept; decode outputs SHALL hold
  imem_req  out  1  fetch request to instruction memory
  imem_addr  out  32  fetch address, word aligned
  imem_gnt  in  1  memory accepted request this cycle
  imem_rvalid  in  1  response data valid this cycle
  imem_rdata  in  WORD_WIDTH  response instruction
  instr_d  out  WORD_WIDTH  instruction to decode
  pc_d  out  32  PC of instr_d
  pc_plus4_d  out  32  pc_d + 4
  valid_d  out  1  instr_d/pc_d/pc_plus4_d valid

Function
REQ-005 States SHALL be IDLE, REQ, WAIT and HOLD; at most one memory request SHALL be outstanding.
REQ-006 IDLE: imem_req=0; next state SHALL be REQ unconditionally.
REQ-007 REQ: imem_req=1, imem_addr=pc_f; imem_gnt=1 -> WAIT; otherwise stay, imem_addr stable unless redirected.
REQ-008 WAIT: imem_req=0; imem_rvalid=1 with stall_d=0 SHALL load instr_d=imem_rdata, pc_d=pc_f, pc_plus4_d=pc_f+4, valid_d=1, pc_f<=pc_f+4, -> REQ.
REQ-009 WAIT: imem_rvalid=1 with stall_d=1 SHALL capture rdata and pc_f into a one-entry hold buffer, -> HOLD; decode outputs unchanged.
REQ-010 HOLD: when stall_d=0, buffer SHALL transfer to decode outputs with valid_d=1, pc_f<=pc_f+4, -> REQ; while stall_d=1, stay.
REQ-011 Any edge with stall_d=0 and no instruction delivered SHALL set valid_d=0 (bubble); stall_d=1 SHALL freeze all decode outputs.
REQ-012 pc_plus4_d and pc_f+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-013 redirect_e=1 in any state SHALL set pc_f<=pc_target_e with bits[1:0] forced to 0, set valid_d<=0, discard hold buffer; flush SHALL override stall_d.
REQ-014 Redirect in REQ with imem_gnt=0: next state REQ, next-cycle imem_addr = new target.
REQ-015 Redirect in REQ with imem_gnt=1, or in WAIT with imem_rvalid=0: set squash flag, -> WAIT; the next response SHALL be discarded, squash cleared, -> REQ.
REQ-016 Redirect in WAIT with imem_rvalid=1, or in HOLD: response/buffer discarded, -> REQ.
REQ-017 A response arriving while squash is set SHALL never reach decode outputs, even if stall_d=0.
REQ-018 imem_rvalid in IDLE, REQ or HOLD SHALL be ignored.

Reset
REQ-019 reset=1 SHALL force state=IDLE, pc_f=RESET_PC, squash=0, hold buffer empty, valid_d=0, instr_d=0, pc_d=0, pc_plus4_d=0, imem_req=0, imem_addr=RESET_PC.
REQ-020 reset mid-request SHALL abandon the outstanding fetch; a later response SHALL be ignored (REQ-018).
REQ-021 reset SHALL take priority over redirect_e and stall_d.

Verification
REQ-022 Reset release, gnt=1 each REQ, rvalid one cycle after gnt, rdata=0x00500093 -> first fetch addr 0x0, valid_d=1 with pc_d=0x0, pc_plus4_d=0x4; next addr 0x4.
REQ-023 rvalid at pc_f=0x8 with stall_d=1 for 3 cycles -> valid_d/instr_d frozen, no imem_req; after release, pc_d=0x8, next request addr 0xC.
REQ-024 redirect_e=1, pc_target_e=0x103 in WAIT, rvalid next cycle rdata=0xDEADBEEF -> 0xDEADBEEF never on instr_d; next imem_addr=0x100.
REQ-025 redirect_e and stall_d both 1 in HOLD -> valid_d=0 next cycle, buffer dropped, next imem_addr=target.
REQ-026 RESET_PC=0xFFFF_FFFC, one fetch -> pc_plus4_d=0x0, next imem_addr=0x0.
REQ-027 gnt held 0 for 5 cycles -> imem_req=1, imem_addr constant; reset asserted in WAIT -> outputs per REQ-019, stray rvalid ignored.

Source files
------------

// File: rtl/ifetch_sequencer.sv
// ============================================================================
// ifetch_sequencer : single-outstanding instruction fetch with decode hold/flush
// Revision 1.0
// ============================================================================
`default_nettype none

module ifetch_sequencer #(
  parameter int          WORD_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_e,
  input  logic [31:0]           pc_target_e,
  input  logic                  stall_d,
  output logic                  imem_req,
  output logic [31:0]           imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [WORD_WIDTH-1:0] imem_rdata,
  output logic [WORD_WIDTH-1:0] instr_d,
  output logic [31:0]           pc_d,
  output logic [31:0]           pc_plus4_d,
  output logic                  valid_d
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [31:0]           r_pc_f;
  logic                  r_squash;
  logic                  w_squash_nxt;
  logic [WORD_WIDTH-1:0] r_hold_instr;

  logic [31:0]           w_target;
  logic [31:0]           w_pc_inc;
  logic                  w_resp_ok;
  logic                  w_deliver;
  logic                  w_capture;
  logic [WORD_WIDTH-1:0] w_deliver_instr;

  assign w_target  = pc_target_e & ~32'h3;
  assign w_pc_inc  = r_pc_f + 32'd4;
  assign w_resp_ok = (r_state == S_WAIT) && imem_rvalid && !r_squash;
  assign w_deliver = !redirect_e && !stall_d && (w_resp_ok || (r_state == S_HOLD));
  assign w_capture = !redirect_e && stall_d && w_resp_ok;
  // pc_f does not move while holding, so it doubles as the held instruction's PC
  assign w_deliver_instr = (r_state == S_HOLD) ? r_hold_instr : imem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_squash_nxt = r_squash;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (imem_gnt) begin
          w_state_nxt  = S_WAIT;
          w_squash_nxt = redirect_e;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_squash_nxt = 1'b0;
          w_state_nxt  = (stall_d && !redirect_e && !r_squash) ? S_HOLD : S_REQ;
        end else if (redirect_e) begin
          w_squash_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_e || !stall_d) begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (r_state == S_REQ);
    imem_addr = r_pc_f;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_f       <= RESET_PC;
      r_squash     <= 1'b0;
      r_hold_instr <= '0;
      instr_d      <= '0;
      pc_d         <= 32'd0;
      pc_plus4_d   <= 32'd0;
      valid_d      <= 1'b0;
    end else begin
      r_squash <= w_squash_nxt;
      if (redirect_e) begin
        r_pc_f <= w_target;
      end else if (w_deliver) begin
        r_pc_f <= w_pc_inc;
      end
      if (w_capture) begin
        r_hold_instr <= imem_rdata;
      end
      if (redirect_e) begin
        valid_d <= 1'b0;
      end else if (!stall_d) begin
        valid_d <= w_deliver;
        if (w_deliver) begin
          instr_d    <= w_deliver_instr;
          pc_d       <= r_pc_f;
          pc_plus4_d <= w_pc_inc;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ifetch_sequencer.sv
// ============================================================================
// tb_ifetch_sequencer : randomized fetch/stall/redirect bench with in-order PC model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ifetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, redirect_e, stall_d, imem_gnt, imem_rvalid;
  logic [31:0] pc_target_e, imem_rdata;
  logic        imem_req, valid_d;
  logic [31:0] imem_addr, instr_d, pc_d, pc_plus4_d;

  ifetch_sequencer #(.WORD_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .redirect_e(redirect_e), .pc_target_e(pc_target_e),
    .stall_d(stall_d), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_d(instr_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  // Instruction memory contents as a pure function of the word address
  function automatic logic [31:0] memf(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  // Stimulus knobs and memory-responder bookkeeping
  int          p_gnt = 0, p_stall = 0, p_redir = 0, p_reset = 0, p_stray = 0, max_lat = 0;
  int          force_stall = 0;
  bit          force_reset = 1'b0;
  bit          outst = 1'b0;
  int          lat = 0;
  logic [31:0] resp_addr = 32'd0;
  logic [31:0] req_addr;
  bit          ov_redir = 1'b0, ov_delay = 1'b0, ov_data_en = 1'b0;
  logic [31:0] ov_target = 32'd0, ov_data = 32'd0;
  logic [31:0] redir_q[$];

  task automatic cycle();
    logic [31:0] rnd;
    @(negedge clk);
    if (imem_req) chk("one_outstanding", {31'd0, outst}, 32'd0);
    req_addr    = imem_addr;
    reset       = force_reset || (($urandom % 1000) < p_reset);
    redirect_e  = ov_redir || (($urandom % 100) < p_redir);
    pc_target_e = ov_redir ? ov_target : $urandom;
    if (redirect_e) redir_q.push_back(pc_target_e);
    stall_d  = (force_stall >= 0) ? force_stall[0] : (($urandom % 100) < p_stall);
    imem_gnt = imem_req && !outst && (($urandom % 100) < p_gnt);
    rnd = $urandom;
    if (outst && lat == 0 && !ov_delay) begin
      imem_rvalid = 1'b1;
      imem_rdata  = ov_data_en ? ov_data : memf(resp_addr);
    end else if (!outst && (($urandom % 100) < p_stray)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = {16'hBAD0, rnd[15:0]};
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = rnd;
    end
    ov_redir = 1'b0; ov_delay = 1'b0; ov_data_en = 1'b0;
    @(posedge clk);
    if (reset) begin
      outst = 1'b0;
    end else begin
      if (outst && imem_rvalid) outst = 1'b0;
      else if (outst && lat > 0) lat--;
      if (imem_gnt) begin
        outst     = 1'b1;
        resp_addr = req_addr;
        lat       = $urandom_range(0, max_lat);
      end
    end
  endtask

  task automatic wait_outst();
    int n = 0;
    while (!outst && n < 50) begin
      cycle();
      n++;
    end
    if (!outst) chk("wait_grant_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: in-order PC stream model; next delivery is previous+4 unless redirected
  logic [31:0] exp_pc = RST_PC;
  logic        pv;
  logic [31:0] pi, ppc, pp4;

  always @(posedge clk) begin
    logic s_reset, s_redir, s_stall;
    logic [31:0] t;
    s_reset = reset; s_redir = redirect_e; s_stall = stall_d;
    #1;
    t = exp_pc;
    if (s_redir === 1'b1) begin
      if (redir_q.size() == 0) chk("redir_queue_empty", 32'd0, 32'd1);
      else t = redir_q.pop_front();
    end
    if (s_reset === 1'b1) begin
      exp_pc = RST_PC;
      chk("rst_valid_d", {31'd0, valid_d}, 32'd0);
      chk("rst_instr_d", instr_d, 32'd0);
      chk("rst_pc_d", pc_d, 32'd0);
      chk("rst_pc_plus4_d", pc_plus4_d, 32'd0);
      chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
      chk("rst_imem_addr", imem_addr, RST_PC);
    end else if (s_redir === 1'b1) begin
      exp_pc = t & ~32'h3;
      chk("flush_valid_d", {31'd0, valid_d}, 32'd0);
    end else if (s_stall === 1'b1) begin
      chk("stall_valid_d", {31'd0, valid_d}, {31'd0, pv});
      chk("stall_instr_d", instr_d, pi);
      chk("stall_pc_d", pc_d, ppc);
      chk("stall_pc_plus4_d", pc_plus4_d, pp4);
    end else if (valid_d === 1'b1) begin
      chk("deliver_pc_d", pc_d, exp_pc);
      chk("deliver_pc_plus4_d", pc_plus4_d, exp_pc + 32'd4);
      chk("deliver_instr_d", instr_d, memf(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    if (imem_req === 1'b1) chk("fetch_addr", imem_addr, exp_pc);
    pv = valid_d; pi = instr_d; ppc = pc_d; pp4 = pc_plus4_d;
  end

  initial begin
    reset = 1'b1; redirect_e = 1'b0; stall_d = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; pc_target_e = 32'd0; imem_rdata = 32'd0;
    // Reset release, immediate grants, one-cycle response latency
    force_reset = 1'b1; repeat (2) cycle();
    force_reset = 1'b0; p_gnt = 100; max_lat = 0; force_stall = 0;
    repeat (20) cycle();
    // Response arrives under stall and is held
    force_stall = 1; wait_outst(); cycle(); repeat (3) cycle();
    force_stall = 0; repeat (10) cycle();
    // Redirect while waiting; the in-flight response must be squashed
    wait_outst();
    ov_redir = 1'b1; ov_target = 32'h0000_0103; ov_delay = 1'b1; cycle();
    ov_data_en = 1'b1; ov_data = 32'hDEAD_BEEF; cycle();
    repeat (10) cycle();
    // Redirect together with stall while holding
    force_stall = 1; wait_outst(); cycle(); cycle();
    ov_redir = 1'b1; ov_target = 32'h0000_0040; cycle();
    force_stall = 0; repeat (10) cycle();
    // PC wrap at top of address space
    ov_redir = 1'b1; ov_target = 32'hFFFF_FFFE; repeat (12) cycle();
    // Grant withheld, then reset mid-fetch with a stray response afterwards
    p_gnt = 0; repeat (6) cycle();
    p_gnt = 100; wait_outst();
    force_reset = 1'b1; cycle(); force_reset = 1'b0;
    p_stray = 100; repeat (2) cycle(); p_stray = 0;
    repeat (10) cycle();
    // Randomized traffic
    p_gnt = 70; max_lat = 3; force_stall = -1; p_stall = 30;
    p_redir = 6; p_reset = 10; p_stray = 10;
    repeat (3000) cycle();
    p_redir = 0; p_reset = 0; p_stray = 0; force_stall = 0;
    repeat (10) cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
